// File: rtl/store_align_if.sv
// Store-request and memory-write-port signal bundle for store_align_unit.
// The unit takes the slave view; the requester/memory side takes the master view.
interface store_align_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [2:0]  req_type;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        done;
  logic        err;

  modport slave (
    input  req_valid, req_addr, req_data, req_type, mem_ready,
    output req_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb, done, err
  );

  modport master (
    output req_valid, req_addr, req_data, req_type, mem_ready,
    input  req_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb, done, err
  );
endinterface

// File: rtl/store_align_unit.sv
// Store alignment: positions SB/SH/SW data into byte lanes with strobes and
// issues word-aligned beats, splitting word-crossing stores when enabled.
module store_align_unit #(
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  store_align_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } state_t;

  state_t      state;
  logic        split_pending;
  logic [31:0] hi_addr;
  logic [31:0] hi_wdata;
  logic [3:0]  hi_wstrb;

  logic        type_ok;
  logic [3:0]  base_mask;
  logic [31:0] data_mask;
  logic [1:0]  offset;
  logic [7:0]  mask8;
  logic [63:0] data64;
  logic        crossing;
  logic        accept;
  logic        reject;
  logic [31:0] word_addr;

  assign bus.req_ready = (state == IDLE);
  assign accept        = bus.req_valid && (state == IDLE);

  // NOTE: every output of always_comb gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    type_ok   = 1'b1;
    base_mask = 4'b0000;
    data_mask = 32'h0000_0000;
    case (bus.req_type)
      3'b000: begin base_mask = 4'b0001; data_mask = 32'h0000_00FF; end
      3'b001: begin base_mask = 4'b0011; data_mask = 32'h0000_FFFF; end
      3'b010: begin base_mask = 4'b1111; data_mask = 32'hFFFF_FFFF; end
      default: type_ok = 1'b0;
    endcase
  end

  // Eight-lane view: lanes 3..0 belong to word A, lanes 7..4 to word A+4.
  // Data is width-masked first so lanes outside the store are always zero.
  assign offset    = bus.req_addr[1:0];
  assign mask8     = {4'b0000, base_mask} << offset;
  assign data64    = {32'h0000_0000, bus.req_data & data_mask} << {offset, 3'b000};
  assign crossing  = |mask8[7:4];
  assign reject    = !type_ok || (crossing && !SPLIT_MISALIGNED);
  assign word_addr = {bus.req_addr[31:2], 2'b00};

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      split_pending <= 1'b0;
      hi_addr       <= '0;
      hi_wdata      <= '0;
      hi_wstrb      <= '0;
      bus.mem_valid <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_wstrb <= '0;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      bus.err  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (reject) begin
              bus.err <= 1'b1;
            end else begin
              bus.mem_valid <= 1'b1;
              bus.mem_addr  <= word_addr;
              bus.mem_wdata <= data64[31:0];
              bus.mem_wstrb <= mask8[3:0];
              split_pending <= crossing;
              hi_addr       <= {bus.req_addr[31:2] + 30'd1, 2'b00};
              hi_wdata      <= data64[63:32];
              hi_wstrb      <= mask8[7:4];
              state         <= BEAT0;
            end
          end
        end
        BEAT0: begin
          if (bus.mem_ready) begin
            if (split_pending) begin
              bus.mem_addr  <= hi_addr;
              bus.mem_wdata <= hi_wdata;
              bus.mem_wstrb <= hi_wstrb;
              state         <= BEAT1;
            end else begin
              bus.mem_valid <= 1'b0;
              bus.done      <= 1'b1;
              state         <= IDLE;
            end
          end
        end
        BEAT1: begin
          if (bus.mem_ready) begin
            bus.mem_valid <= 1'b0;
            bus.done      <= 1'b1;
            split_pending <= 1'b0;
            state         <= IDLE;
          end
        end
        default: begin
          bus.mem_valid <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_align_unit.sv
// Directed bench for store_align_unit: lane placement, split beats, rejects,
// backpressure and mid-store reset, on split-enabled and split-disabled copies.
module tb_store_align_unit;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  store_align_if bus_s();
  store_align_if bus_n();

  store_align_unit #(.SPLIT_MISALIGNED(1'b1)) u_split (
    .clk(clk), .rst_n(rst_n), .bus(bus_s)
  );
  store_align_unit #(.SPLIT_MISALIGNED(1'b0)) u_nosplit (
    .clk(clk), .rst_n(rst_n), .bus(bus_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one request on the split DUT with mem_ready=1 and checks each beat
  // and the done pulse on its exact cycle.
  task automatic store_check(input string tag, input logic [31:0] addr,
                             input logic [31:0] data, input logic [2:0] typ,
                             input bit two,
                             input logic [31:0] a0, input logic [31:0] d0, input logic [3:0] s0,
                             input logic [31:0] a1, input logic [31:0] d1, input logic [3:0] s1);
    bus_s.req_valid = 1'b1;
    bus_s.req_addr  = addr;
    bus_s.req_data  = data;
    bus_s.req_type  = typ;
    bus_s.mem_ready = 1'b1;
    tick();
    bus_s.req_valid = 1'b0;
    bus_s.req_data  = 32'h5555_5555;
    check({tag, " b0 valid"}, bus_s.mem_valid, 1'b1);
    check({tag, " b0 addr"},  bus_s.mem_addr,  a0);
    check({tag, " b0 wdata"}, bus_s.mem_wdata, d0);
    check({tag, " b0 wstrb"}, bus_s.mem_wstrb, s0);
    check({tag, " b0 ready"}, bus_s.req_ready, 1'b0);
    if (two) begin
      tick();
      check({tag, " b1 valid"}, bus_s.mem_valid, 1'b1);
      check({tag, " b1 addr"},  bus_s.mem_addr,  a1);
      check({tag, " b1 wdata"}, bus_s.mem_wdata, d1);
      check({tag, " b1 wstrb"}, bus_s.mem_wstrb, s1);
      check({tag, " b1 done"},  bus_s.done,      1'b0);
    end
    tick();
    check({tag, " end valid"}, bus_s.mem_valid, 1'b0);
    check({tag, " end done"},  bus_s.done,      1'b1);
    check({tag, " end ready"}, bus_s.req_ready, 1'b1);
    check({tag, " end err"},   bus_s.err,       1'b0);
    tick();
    check({tag, " done pulse"}, bus_s.done, 1'b0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus_s.req_valid = 1'b0; bus_s.req_addr = '0; bus_s.req_data = '0;
    bus_s.req_type  = 3'b000; bus_s.mem_ready = 1'b0;
    bus_n.req_valid = 1'b0; bus_n.req_addr = '0; bus_n.req_data = '0;
    bus_n.req_type  = 3'b000; bus_n.mem_ready = 1'b0;

    #12;
    check("rst valid", bus_s.mem_valid, 1'b0);
    check("rst addr",  bus_s.mem_addr,  32'h0);
    check("rst wdata", bus_s.mem_wdata, 32'h0);
    check("rst wstrb", bus_s.mem_wstrb, 4'h0);
    check("rst done",  bus_s.done,      1'b0);
    check("rst err",   bus_s.err,       1'b0);
    check("rst ready", bus_s.req_ready, 1'b1);
    rst_n = 1'b1;
    tick();

    store_check("sw100", 32'h100, 32'hDEADBEEF, 3'b010, 1'b0,
                32'h100, 32'hDEADBEEF, 4'b1111, 32'h0, 32'h0, 4'h0);
    store_check("sb203", 32'h203, 32'h000000A5, 3'b000, 1'b0,
                32'h200, 32'hA5000000, 4'b1000, 32'h0, 32'h0, 4'h0);
    store_check("sh202", 32'h202, 32'h00001234, 3'b001, 1'b0,
                32'h200, 32'h12340000, 4'b1100, 32'h0, 32'h0, 4'h0);
    store_check("sb101", 32'h101, 32'hFFFFFF5A, 3'b000, 1'b0,
                32'h100, 32'h00005A00, 4'b0010, 32'h0, 32'h0, 4'h0);
    store_check("sh001", 32'h001, 32'hABCD1234, 3'b001, 1'b0,
                32'h000, 32'h00123400, 4'b0110, 32'h0, 32'h0, 4'h0);
    store_check("sw103", 32'h103, 32'h11223344, 3'b010, 1'b1,
                32'h100, 32'h44000000, 4'b1000, 32'h104, 32'h00112233, 4'b0111);
    store_check("shwrap", 32'hFFFFFFFF, 32'h0000BEEF, 3'b001, 1'b1,
                32'hFFFFFFFC, 32'hEF000000, 4'b1000, 32'h0, 32'h000000BE, 4'b0001);

    // Illegal funct3 on the split-enabled unit.
    bus_s.req_valid = 1'b1; bus_s.req_addr = 32'h300; bus_s.req_data = 32'h1;
    bus_s.req_type  = 3'b011;
    tick();
    bus_s.req_valid = 1'b0;
    check("ill err",   bus_s.err,       1'b1);
    check("ill valid", bus_s.mem_valid, 1'b0);
    check("ill done",  bus_s.done,      1'b0);
    check("ill ready", bus_s.req_ready, 1'b1);
    tick();
    check("ill err pulse", bus_s.err,       1'b0);
    check("ill no beat",   bus_s.mem_valid, 1'b0);

    // Crossing store with splitting disabled.
    bus_n.mem_ready = 1'b1;
    bus_n.req_valid = 1'b1; bus_n.req_addr = 32'h103; bus_n.req_data = 32'h11223344;
    bus_n.req_type  = 3'b010;
    tick();
    bus_n.req_valid = 1'b0;
    check("nosplit err",   bus_n.err,       1'b1);
    check("nosplit valid", bus_n.mem_valid, 1'b0);
    tick();
    check("nosplit err pulse", bus_n.err,       1'b0);
    check("nosplit no beat",   bus_n.mem_valid, 1'b0);
    check("nosplit ready",     bus_n.req_ready, 1'b1);
    // Aligned store still goes through on the split-disabled unit.
    bus_n.req_valid = 1'b1; bus_n.req_addr = 32'h203; bus_n.req_data = 32'h000000A5;
    bus_n.req_type  = 3'b000;
    tick();
    bus_n.req_valid = 1'b0;
    check("nosplit sb valid", bus_n.mem_valid, 1'b1);
    check("nosplit sb wdata", bus_n.mem_wdata, 32'hA5000000);
    check("nosplit sb err",   bus_n.err,       1'b0);
    tick();
    check("nosplit sb done",  bus_n.done,      1'b1);

    // Backpressure: beat held stable, request inputs ignored while busy.
    bus_s.mem_ready = 1'b0;
    bus_s.req_valid = 1'b1; bus_s.req_addr = 32'h104; bus_s.req_data = 32'hCAFEF00D;
    bus_s.req_type  = 3'b010;
    tick();
    bus_s.req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus_s.req_addr = 32'h0000_0ABC + i;
      bus_s.req_data = 32'h1234_0000 + i;
      check("bp valid", bus_s.mem_valid, 1'b1);
      check("bp addr",  bus_s.mem_addr,  32'h104);
      check("bp wdata", bus_s.mem_wdata, 32'hCAFEF00D);
      check("bp wstrb", bus_s.mem_wstrb, 4'b1111);
      check("bp ready", bus_s.req_ready, 1'b0);
      check("bp done",  bus_s.done,      1'b0);
      tick();
    end
    bus_s.mem_ready = 1'b1;
    tick();
    check("bp release done",  bus_s.done,      1'b1);
    check("bp release valid", bus_s.mem_valid, 1'b0);
    tick();

    // Reset while the second beat of a split store is stalled.
    bus_s.req_valid = 1'b1; bus_s.req_addr = 32'h103; bus_s.req_data = 32'h11223344;
    bus_s.req_type  = 3'b010; bus_s.mem_ready = 1'b1;
    tick();
    bus_s.req_valid = 1'b0;
    tick();
    bus_s.mem_ready = 1'b0;
    check("rb beat1 valid", bus_s.mem_valid, 1'b1);
    check("rb beat1 addr",  bus_s.mem_addr,  32'h104);
    #2;
    rst_n = 1'b0;
    #1;
    check("rb async valid", bus_s.mem_valid, 1'b0);
    check("rb async strb",  bus_s.mem_wstrb, 4'h0);
    tick();
    #2;
    rst_n = 1'b1;
    bus_s.mem_ready = 1'b1;
    tick();
    check("rb post ready", bus_s.req_ready, 1'b1);
    check("rb post done",  bus_s.done,      1'b0);
    check("rb post valid", bus_s.mem_valid, 1'b0);
    tick();
    check("rb post done2", bus_s.done,      1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/store_align_unit.md
Name: store_align_unit

Overview:
- Write-side counterpart of the core's load-alignment path; sits between execute/memory stage and the data-memory write port.
- Accepts one store request (address, raw rs2 data, funct3 width) over a valid/ready handshake.
- Generates lane-shifted write data and byte strobes, and issues word-aligned beats on a valid/ready memory port.
- Misaligned stores that cross a word boundary are split into two beats, or flagged as errors when splitting is disabled.

Parameters:
- SPLIT_MISALIGNED, 1, 1 = split word-crossing stores into two beats; 0 = reject them with err.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  store request valid.
- req_ready  output  1  unit can accept a request.
- req_addr  input  32  byte address.
- req_data  input  32  store data, LSB-justified.
- req_type  input  3  funct3: 000 SB, 001 SH, 010 SW; all other codes are illegal.
- mem_valid  output  1  memory beat valid.
- mem_ready  input  1  memory accepts beat.
- mem_addr  output  32  word-aligned beat address; bits [1:0] always 00.
- mem_wdata  output  32  lane-positioned write data.
- mem_wstrb  output  4  byte strobes; bit i enables byte lane i.
- done  output  1  one-cycle pulse when a store completes.
- err  output  1  one-cycle pulse when a request is rejected.

Behaviour:
- Reset (async, while rst_n=0):
  - state=IDLE; mem_valid=0; mem_addr=0; mem_wdata=0; mem_wstrb=0; done=0; err=0.
  - Any in-flight beat is abandoned immediately; no beat is pending after release.
- States: IDLE, BEAT0, BEAT1.
- req_ready = (state==IDLE), combinational.
- A request is accepted on a rising edge with req_valid & req_ready.
- Width w: SB=1, SH=2, SW=4. Offset o = req_addr[1:0].
- Composite 8-lane view:
  - M8 = ((1<<w)-1) << o
  - D64 = {32'b0, req_data} << (8*o)
  - Lower halves belong to word A = {req_addr[31:2], 2'b00}; upper halves belong to word A+4 (mod 2^32; 0xFFFFFFFC+4 wraps to 0).
- Legal single beat (o+w <= 4):
  - Next cycle: mem_valid=1, mem_addr=A, mem_wdata=D64[31:0], mem_wstrb=M8[3:0]; state=BEAT0.
  - Unused lanes of mem_wdata are 0.
- Crossing (o+w > 4) with SPLIT_MISALIGNED=1:
  - BEAT0 carries the lower half (as above).
  - After the BEAT0 handshake, the next cycle presents mem_addr=A+4, mem_wdata=D64[63:32], mem_wstrb=M8[7:4]; state=BEAT1.
- Crossing with SPLIT_MISALIGNED=0, or illegal req_type:
  - No beat is issued; err=1 the cycle after accept; state stays IDLE.
  - Request bits are not captured.
- While mem_valid=1 and mem_ready=0: mem_addr, mem_wdata and mem_wstrb hold stable; mem_valid is never withdrawn except by reset.
- Final beat handshake (mem_valid & mem_ready) at edge k:
  - At k+1: mem_valid=0, done=1 for one cycle, state=IDLE, req_ready=1.
  - Minimum accept-to-done is 2 cycles for a single beat and 3 for a split store, with mem_ready held at 1.
- mem_ready is ignored while mem_valid=0.
- A new request may be accepted in the same cycle that done or err is high.
- Request inputs are sampled only at accept; later changes have no effect on the store in flight.
- done and err are never high in the same cycle.

Test Plan:
- SW addr=0x100, data=0xDEADBEEF, mem_ready=1 -> one beat: addr 0x100, wdata 0xDEADBEEF, wstrb 1111; done 2 cycles after accept.
- SB addr=0x203, data=0x000000A5 -> addr 0x200, wdata 0xA5000000, wstrb 1000. SH addr=0x202, data=0x1234 -> wdata 0x12340000, wstrb 1100.
- SW addr=0x103, data=0x11223344, SPLIT=1 -> beat0: addr 0x100, wdata 0x44000000, wstrb 1000; beat1: addr 0x104, wdata 0x00112233, wstrb 0111; single done pulse. Same request with SPLIT=0 -> err pulse, no mem_valid.
- SH addr=0xFFFFFFFF, data=0xBEEF -> beat0 addr 0xFFFFFFFC, wstrb 1000, wdata 0xEF000000; beat1 addr 0x00000000, wstrb 0001, wdata 0x000000BE.
- Backpressure: mem_ready=0 for 5 cycles during BEAT0 -> outputs stable and req_ready=0 throughout; req_type=011 -> err pulse and no beat.
- Reset asserted mid-BEAT1 -> mem_valid drops to 0 asynchronously; after release req_ready=1 and no done pulse.
